// File: rtl/magma_bus_arbiter.sv
// rtl/magma_bus_arbiter.sv - two-master req/ack/resp bus arbiter with in-order read response routing
// Define MAGMA_ARB_UDM_PRIO_EN to give the UDM bridge (master 1) fixed priority on ties.
module magma_bus_arbiter #(
    parameter int RD_FIFO_DEPTH = 4,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RD_FIFO_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state, state_nxt;
    logic                     owner, owner_nxt;
    logic                     last_grant, last_grant_nxt;
    logic [RD_FIFO_DEPTH-1:0] fifo_mem;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         fifo_cnt;

    logic elig0, elig1;
    logic grant, sel, sel_we;
    logic push, pop, head;

    // Reads are only admitted while a FIFO slot is free; the registered count is used
    // so a pop in the same cycle never frees a slot early.
    assign elig0 = m0_req_i && (m0_we_i || (fifo_cnt < FIFO_FULL));
    assign elig1 = m1_req_i && (m1_we_i || (fifo_cnt < FIFO_FULL));

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        grant          = 1'b0;
        sel            = 1'b0;
        if (!arst_i) begin
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant = 1'b1;
                        if (elig0 && elig1) begin
`ifdef MAGMA_ARB_UDM_PRIO_EN
                            sel = 1'b1;
`else
                            sel = !last_grant;
`endif
                        end else begin
                            sel = elig1;
                        end
                        if (s_ack_i) begin
                            last_grant_nxt = sel;
                        end else begin
                            owner_nxt = sel;
                            state_nxt = BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Locked grant: the other master is ignored until the slave acks.
                    grant = 1'b1;
                    sel   = owner;
                    if (s_ack_i) begin
                        last_grant_nxt = owner;
                        state_nxt      = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (grant) begin
            s_req_o   = 1'b1;
            s_we_o    = sel ? m1_we_i    : m0_we_i;
            s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            s_be_o    = sel ? m1_be_i    : m0_be_i;
            s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign sel_we   = sel ? m1_we_i : m0_we_i;
    assign m0_ack_o = s_ack_i && s_req_o && !sel;
    assign m1_ack_o = s_ack_i && s_req_o && sel;
    assign push     = grant && s_ack_i && !sel_we;

    // A response with nothing outstanding has no owner and is silently discarded.
    assign pop  = s_resp_i && (fifo_cnt != '0) && !arst_i;
    assign head = fifo_mem[rd_ptr];

    assign m0_resp_o  = pop && !head;
    assign m1_resp_o  = pop && head;
    assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
    assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            fifo_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sel;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_magma_bus_arbiter.sv
// tb/tb_magma_bus_arbiter.sv - table-driven directed bench for magma_bus_arbiter
module tb_magma_bus_arbiter;

`ifdef MAGMA_ARB_UDM_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b0;
    logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
    logic [3:0]  m0_be_i = 4'hF;
    logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
    logic [3:0]  m1_be_i = 4'h3;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_ack_i = 1'b0, s_resp_i = 1'b0;
    logic [31:0] s_rdata_i = '0;

    magma_bus_arbiter dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       nm;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        ack, resp;
        logic [31:0] rd;
        int          sel;   // expected granted master, -1 = no request to slave
        logic        ep0, ep1;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic v(input string nm, input logic r0, w0, input logic [31:0] a0, d0,
                     input logic r1, w1, input logic [31:0] a1, d1,
                     input logic ack, resp, input logic [31:0] rd, input int sel,
                     input logic ep0, ep1);
        vec_t e;
        e.nm = nm; e.r0 = r0; e.w0 = w0; e.a0 = a0; e.d0 = d0;
        e.r1 = r1; e.w1 = w1; e.a1 = a1; e.d1 = d1;
        e.ack = ack; e.resp = resp; e.rd = rd; e.sel = sel; e.ep0 = ep0; e.ep1 = ep1;
        tbl.push_back(e);
    endtask

    task automatic idle(input string nm);
        v(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t e);
        m0_req_i = e.r0; m0_we_i = e.w0; m0_addr_i = e.a0; m0_wdata_i = e.d0;
        m1_req_i = e.r1; m1_we_i = e.w1; m1_addr_i = e.a1; m1_wdata_i = e.d1;
        s_ack_i = e.ack; s_resp_i = e.resp; s_rdata_i = e.rd;
    endtask

    initial begin
        vec_t        e;
        logic [137:0] got, exp;
        logic [69:0]  cmd;

        // Reset state: outputs stay 0 even with a request present.
        #2 arst_i = 1'b1;
        @(negedge clk_i);
        m0_req_i = 1'b1; s_ack_i = 1'b1;
        #1;
        chk("reset_outputs",
            {s_req_o, s_we_o, s_addr_o, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o},
            64'h0);
        @(negedge clk_i);
        arst_i = 1'b0; m0_req_i = 1'b0; s_ack_i = 1'b0;

        // Single read, response two cycles later.
        v("rd0_ack", 1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("rd0_gap");
        v("rd0_resp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h123455AA, -1, 1, 0);

        // Continuous tie of writes with immediate ack.
        for (int i = 0; i < 4; i++)
            v("tie", 1, 1, 32'h100, 32'h11111111, 1, 1, 32'h200, 32'h22222222, 1, 0, 0,
              PRIO ? 1 : ((i % 2 == 0) ? 1 : 0), 0, 0);

        // m1 write held for 3 wait cycles while m0 also requests.
        for (int i = 0; i < 4; i++)
            v("busy_hold", 1, 1, 32'h300, 32'h33333333, 1, 1, 32'h80000000, 32'h5AAA5AAA,
              (i == 3), 0, 0, 1, 0, 0);
        v("after_busy", 1, 1, 32'h300, 32'h33333333, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Fill the read FIFO, then block a fifth read while a write still goes through.
        for (int i = 0; i < 4; i++)
            v("rd_fill", 1, 0, 32'h400 + 4 * i, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v("rd5_blocked", 1, 0, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0, 0);
        v("wr_when_full", 1, 0, 32'h500, 0, 1, 1, 32'h600, 32'h66666666, 1, 0, 0, 1, 0, 0);
        v("pop_no_bypass", 1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, -1, 1, 0);
        v("rd5_granted", 1, 0, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            v("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0002 + i, -1, 1, 0);

        // Interleaved reads routed back in order, with a push/pop in one cycle.
        v("il_rd_m0", 1, 0, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v("il_rd_m1", 0, 0, 0, 0, 1, 0, 32'h704, 0, 1, 0, 0, 1, 0, 0);
        v("il_rd_m0b", 1, 0, 32'h708, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v("il_resp_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB0, -1, 1, 0);
        v("il_resp_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB1, -1, 0, 1);
        v("il_push_pop", 0, 0, 0, 0, 1, 0, 32'h70C, 0, 1, 1, 32'hB2, 1, 1, 0);
        v("il_resp_d", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB3, -1, 0, 1);
        v("spurious_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, -1, 0, 0);
        v("spurious_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF, -1, 0, 0);

        // Two reads outstanding, then a write parked in BUSY.
        v("pre_rst_rd0", 1, 0, 32'h800, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v("pre_rst_rd1", 0, 0, 0, 0, 1, 0, 32'h804, 0, 1, 0, 0, 1, 0, 0);
        v("pre_rst_busy", 1, 1, 32'h900, 32'h99999999, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            e = tbl[k];
            @(negedge clk_i);
            drive(e);
            #1;
            if (e.sel == 0)      cmd = {1'b1, e.w0, e.a0, 4'hF, e.d0};
            else if (e.sel == 1) cmd = {1'b1, e.w1, e.a1, 4'h3, e.d1};
            else                 cmd = '0;
            exp = {cmd, e.ack && (e.sel == 0), e.ack && (e.sel == 1), e.ep0, e.ep1,
                   e.ep0 ? e.rd : 32'h0, e.ep1 ? e.rd : 32'h0};
            got = {s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o, m0_ack_o, m1_ack_o,
                   m0_resp_o, m1_resp_o, m0_rdata_o, m1_rdata_o};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s[%0d]: got %h expected %h", e.nm, k, got, exp);
            end
        end

        // Reset while BUSY: grant drops at once, late responses are dropped.
        @(negedge clk_i);
        arst_i = 1'b1; s_ack_i = 1'b1;
        #1;
        chk("rst_grant_drop", {s_req_o, m0_ack_o, m1_ack_o}, 64'h0);
        @(negedge clk_i);
        arst_i = 1'b0; m0_req_i = 1'b0; s_ack_i = 1'b0;
        s_resp_i = 1'b1; s_rdata_i = 32'h77;
        #1;
        chk("rst_resp_drop_a", {m0_resp_o, m1_resp_o, m0_rdata_o, m1_rdata_o}, 64'h0);
        @(negedge clk_i);
        s_rdata_i = 32'h78;
        #1;
        chk("rst_resp_drop_b", {m0_resp_o, m1_resp_o, m0_rdata_o, m1_rdata_o}, 64'h0);
        @(negedge clk_i);
        s_resp_i = 1'b0;
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'hA00;
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'hB00;
        s_ack_i = 1'b1;
        #1;
        chk("rst_first_tie", {s_addr_o, 30'h0, m0_ack_o, m1_ack_o},
            PRIO ? {32'hB00, 30'h0, 2'b01} : {32'hA00, 30'h0, 2'b10});
        @(negedge clk_i);
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
